// File: rtl/car_call_register.sv
// Car-panel call register: synchronized, debounced floor buttons latch pending
// calls per car; door-open button produces a stretched force_open request.
module car_call_register #(
    parameter int N_FLOORS    = 12,
    parameter int N_LIFTS     = 10,
    parameter int DEB_CYCLES  = 4,
    parameter int HOLD_CYCLES = 8
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [N_FLOORS-1:0]           btn_raw      [N_LIFTS-1:0],
    input  logic [N_LIFTS-1:0]            door_btn_raw,
    input  logic [N_FLOORS-1:0]           floor_sense  [N_LIFTS-1:0],
    input  logic [N_LIFTS-1:0]            door_open,
    output logic [N_FLOORS-1:0]           flr_rqst     [N_LIFTS-1:0],
    output logic [N_LIFTS-1:0]            force_open,
    output logic [$clog2(N_FLOORS+1)-1:0] pend_cnt     [N_LIFTS-1:0]
);
    localparam int DW = $clog2(DEB_CYCLES + 1);
    localparam int HW = (HOLD_CYCLES > 0) ? $clog2(HOLD_CYCLES + 1) : 1;
    localparam int CW = $clog2(N_FLOORS + 1);
    localparam logic [DW-1:0] DEB_MAX  = DW'(DEB_CYCLES);
    localparam logic [DW-1:0] DEB_PRE  = DW'(DEB_CYCLES - 1);
    localparam logic [HW-1:0] HOLD_MAX = HW'(HOLD_CYCLES);

    logic [N_FLOORS-1:0] bmeta_q [N_LIFTS-1:0];
    logic [N_FLOORS-1:0] bmeta_d [N_LIFTS-1:0];
    logic [N_FLOORS-1:0] bsync_q [N_LIFTS-1:0];
    logic [N_FLOORS-1:0] bsync_d [N_LIFTS-1:0];
    logic [DW-1:0]       bcnt_q  [N_LIFTS-1:0][N_FLOORS-1:0];
    logic [DW-1:0]       bcnt_d  [N_LIFTS-1:0][N_FLOORS-1:0];
    logic [N_FLOORS-1:0] flr_q   [N_LIFTS-1:0];
    logic [N_FLOORS-1:0] flr_d   [N_LIFTS-1:0];
    logic [CW-1:0]       pend_q  [N_LIFTS-1:0];
    logic [CW-1:0]       pend_d  [N_LIFTS-1:0];
    logic [N_LIFTS-1:0]  dmeta_q, dmeta_d;
    logic [N_LIFTS-1:0]  dsync_q, dsync_d;
    logic [DW-1:0]       dcnt_q  [N_LIFTS-1:0];
    logic [DW-1:0]       dcnt_d  [N_LIFTS-1:0];
    logic [HW-1:0]       hold_q  [N_LIFTS-1:0];
    logic [HW-1:0]       hold_d  [N_LIFTS-1:0];
    logic [N_LIFTS-1:0]  fo_q, fo_d;

    always_comb begin
        bmeta_d = btn_raw;
        bsync_d = bmeta_q;
        dmeta_d = door_btn_raw;
        dsync_d = dmeta_q;
        bcnt_d  = bcnt_q;
        flr_d   = flr_q;
        pend_d  = pend_q;
        dcnt_d  = dcnt_q;
        hold_d  = hold_q;
        fo_d    = fo_q;
        for (int i = 0; i < N_LIFTS; i++) begin
            pend_d[i] = '0;
            for (int f = 0; f < N_FLOORS; f++) begin
                if (!bsync_q[i][f])
                    bcnt_d[i][f] = '0;
                else if (bcnt_q[i][f] != DEB_MAX)
                    bcnt_d[i][f] = bcnt_q[i][f] + DW'(1);
                // Set fires on the edge the counter reaches DEB_MAX; a
                // serving door at this floor wins over a new press.
                flr_d[i][f] = (flr_q[i][f]
                              | (bsync_q[i][f] && (bcnt_q[i][f] == DEB_PRE)))
                              && !(door_open[i] && floor_sense[i][f]);
                pend_d[i] = pend_d[i] + CW'(flr_q[i][f]);
            end
            if (!dsync_q[i])
                dcnt_d[i] = '0;
            else if (dcnt_q[i] != DEB_MAX)
                dcnt_d[i] = dcnt_q[i] + DW'(1);
            if (dcnt_q[i] == DEB_MAX)
                hold_d[i] = HOLD_MAX;
            else if (hold_q[i] != '0)
                hold_d[i] = hold_q[i] - HW'(1);
            else
                hold_d[i] = '0;
            fo_d[i] = (dcnt_d[i] == DEB_MAX) || (hold_d[i] != '0);
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bmeta_q <= '{default: '0};
            bsync_q <= '{default: '0};
            bcnt_q  <= '{default: '0};
            flr_q   <= '{default: '0};
            pend_q  <= '{default: '0};
            dmeta_q <= '0;
            dsync_q <= '0;
            dcnt_q  <= '{default: '0};
            hold_q  <= '{default: '0};
            fo_q    <= '0;
        end else begin
            bmeta_q <= bmeta_d;
            bsync_q <= bsync_d;
            bcnt_q  <= bcnt_d;
            flr_q   <= flr_d;
            pend_q  <= pend_d;
            dmeta_q <= dmeta_d;
            dsync_q <= dsync_d;
            dcnt_q  <= dcnt_d;
            hold_q  <= hold_d;
            fo_q    <= fo_d;
        end
    end

    assign flr_rqst   = flr_q;
    assign force_open = fo_q;
    assign pend_cnt   = pend_q;

endmodule

// File: tb/tb_car_call_register.sv
// Bench for car_call_register: directed scenarios plus randomized traffic
// checked against a run-length based reference model.
module tb_car_call_register;
    localparam int NF   = 12;
    localparam int NL   = 10;
    localparam int DEB  = 4;
    localparam int HOLD = 8;
    localparam int CW   = $clog2(NF + 1);

    logic          clk;
    logic          reset;
    logic [NF-1:0] btn_raw     [NL-1:0];
    logic [NL-1:0] door_btn_raw;
    logic [NF-1:0] floor_sense [NL-1:0];
    logic [NL-1:0] door_open;
    logic [NF-1:0] flr_rqst    [NL-1:0];
    logic [NL-1:0] force_open;
    logic [CW-1:0] pend_cnt    [NL-1:0];

    int errors = 0;
    int checks = 0;

    car_call_register #(
        .N_FLOORS(NF), .N_LIFTS(NL), .DEB_CYCLES(DEB), .HOLD_CYCLES(HOLD)
    ) dut (
        .clk(clk), .reset(reset), .btn_raw(btn_raw),
        .door_btn_raw(door_btn_raw), .floor_sense(floor_sense),
        .door_open(door_open), .flr_rqst(flr_rqst),
        .force_open(force_open), .pend_cnt(pend_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Reference model: a call is accepted when the raw input has been seen
    // high for exactly DEB consecutive samples, two samples ago.
    int            run0 [NL][NF];
    int            run1 [NL][NF];
    int            run2 [NL][NF];
    int            drun0 [NL];
    int            drun1 [NL];
    int            drun2 [NL];
    int            last_deb [NL];
    int            edge_n = 0;
    logic [NF-1:0] exp_flr [NL];
    int            exp_pend [NL];
    logic [NL-1:0] exp_force;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < NL; i++) begin
                for (int f = 0; f < NF; f++) begin
                    run0[i][f] = 0; run1[i][f] = 0; run2[i][f] = 0;
                end
                drun0[i] = 0; drun1[i] = 0; drun2[i] = 0;
                last_deb[i] = -1000;
                exp_flr[i] = '0;
                exp_pend[i] = 0;
            end
            exp_force = '0;
        end else begin
            edge_n++;
            for (int i = 0; i < NL; i++) begin
                exp_pend[i] = $countones(exp_flr[i]);
                for (int f = 0; f < NF; f++) begin
                    run2[i][f] = run1[i][f];
                    run1[i][f] = run0[i][f];
                    run0[i][f] = btn_raw[i][f] ? (run0[i][f] < 1000 ? run0[i][f] + 1 : 1000) : 0;
                    if (run2[i][f] == DEB) exp_flr[i][f] = 1'b1;
                    if (door_open[i] && floor_sense[i][f]) exp_flr[i][f] = 1'b0;
                end
                drun2[i] = drun1[i];
                drun1[i] = drun0[i];
                drun0[i] = door_btn_raw[i] ? (drun0[i] < 1000 ? drun0[i] + 1 : 1000) : 0;
                if (drun2[i] >= DEB) last_deb[i] = edge_n;
                exp_force[i] = (edge_n - last_deb[i]) <= HOLD;
            end
        end
    end

    task automatic clear_inputs();
        for (int i = 0; i < NL; i++) begin
            btn_raw[i] = '0;
            floor_sense[i] = '0;
        end
        door_btn_raw = '0;
        door_open = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_reset();
        for (int c = 0; c < 3; c++) begin
            for (int i = 0; i < NL; i++) begin
                btn_raw[i] = NF'($urandom);
                floor_sense[i] = NF'($urandom);
            end
            door_btn_raw = NL'($urandom);
            door_open = NL'($urandom);
            @(negedge clk);
            for (int i = 0; i < NL; i++) begin
                checks++;
                if (flr_rqst[i] !== '0 || pend_cnt[i] !== '0) begin
                    errors++;
                    $display("FAIL reset_hold car=%0d flr=%h pend=%0d want 0", i, flr_rqst[i], pend_cnt[i]);
                end
            end
            checks++;
            if (force_open !== '0) begin
                errors++;
                $display("FAIL reset_hold force_open=%h want 0", force_open);
            end
        end
        clear_inputs();
        for (int i = 0; i < NL; i++) btn_raw[i] = '1;
        door_btn_raw = '1;
        reset = 1'b1;
        for (int e = 1; e <= 8; e++) begin
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < NL; i++) begin
                checks++;
                if (flr_rqst[i] !== (e >= 6 ? {NF{1'b1}} : {NF{1'b0}})) begin
                    errors++;
                    $display("FAIL reset_release e=%0d car=%0d flr=%h", e, i, flr_rqst[i]);
                end
                checks++;
                if (pend_cnt[i] !== (e >= 7 ? CW'(NF) : CW'(0))) begin
                    errors++;
                    $display("FAIL reset_release_pend e=%0d car=%0d got=%0d", e, i, pend_cnt[i]);
                end
            end
            checks++;
            if (force_open !== (e >= 6 ? {NL{1'b1}} : {NL{1'b0}})) begin
                errors++;
                $display("FAIL reset_release_force e=%0d got=%h", e, force_open);
            end
        end
    endtask

    task automatic test_single_press();
        do_reset();
        for (int e = 1; e <= 16; e++) begin
            btn_raw[2][5] = (e <= 10);
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (flr_rqst[2] !== (e >= 6 ? NF'(1) << 5 : NF'(0))) begin
                errors++;
                $display("FAIL single_flr e=%0d got=%h", e, flr_rqst[2]);
            end
            checks++;
            if (pend_cnt[2] !== (e >= 7 ? CW'(1) : CW'(0))) begin
                errors++;
                $display("FAIL single_pend e=%0d got=%0d", e, pend_cnt[2]);
            end
        end
    endtask

    task automatic test_short_pulse();
        do_reset();
        for (int e = 1; e <= 10; e++) begin
            btn_raw[0][3] = (e <= DEB - 1);
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (flr_rqst[0] !== '0) begin
                errors++;
                $display("FAIL short_pulse e=%0d got=%h want 0", e, flr_rqst[0]);
            end
        end
        for (int e = 1; e <= 8; e++) begin
            btn_raw[0][3] = (e <= DEB);
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (flr_rqst[0][3] !== (e >= DEB + 2)) begin
                errors++;
                $display("FAIL exact_pulse e=%0d got=%b", e, flr_rqst[0][3]);
            end
        end
    endtask

    task automatic test_clear_collision();
        do_reset();
        for (int e = 1; e <= 10; e++) begin
            btn_raw[1][4] = (e <= 5);
            @(posedge clk);
            @(negedge clk);
        end
        checks++;
        if (flr_rqst[1] !== NF'(1) << 4) begin
            errors++;
            $display("FAIL collide_pre got=%h want=%h", flr_rqst[1], NF'(1) << 4);
        end
        for (int e = 1; e <= 10; e++) begin
            btn_raw[1][4] = 1'b1;
            floor_sense[1] = (e == 6) ? NF'(1) << 4 : NF'(0);
            door_open[1] = (e == 6);
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (flr_rqst[1][4] !== (e < 6)) begin
                errors++;
                $display("FAIL collide_flr e=%0d got=%b want=%b", e, flr_rqst[1][4], e < 6);
            end
            if (e >= 7) begin
                checks++;
                if (pend_cnt[1] !== CW'(0)) begin
                    errors++;
                    $display("FAIL collide_pend e=%0d got=%0d want 0", e, pend_cnt[1]);
                end
            end
        end
        clear_inputs();
    endtask

    task automatic test_force_open();
        logic [NL-1:0] want;
        do_reset();
        for (int e = 1; e <= 30; e++) begin
            door_btn_raw[3] = (e <= 6) || (e >= 10 && e <= 15);
            @(posedge clk);
            @(negedge clk);
            want = (e >= 6 && e <= 25) ? NL'(1) << 3 : NL'(0);
            checks++;
            if (force_open !== want) begin
                errors++;
                $display("FAIL force_open e=%0d got=%h want=%h", e, force_open, want);
            end
        end
    endtask

    task automatic test_all_cars();
        logic [NF-1:0] mask [NL];
        int a0, a1;
        do_reset();
        a0 = 0; a1 = 0;
        for (int i = 0; i < NL; i++) begin
            int a, b;
            a = $urandom_range(0, NF - 1);
            b = (a + $urandom_range(1, NF - 1)) % NF;
            mask[i] = (NF'(1) << a) | (NF'(1) << b);
            if (i == 0) a0 = a;
            if (i == 1) a1 = a;
        end
        for (int e = 1; e <= 7; e++) begin
            for (int i = 0; i < NL; i++) btn_raw[i] = (e <= 5) ? mask[i] : NF'(0);
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < NL; i++) begin
                if (e >= 5) begin
                    checks++;
                    if (flr_rqst[i] !== (e >= 6 ? mask[i] : NF'(0))) begin
                        errors++;
                        $display("FAIL all_cars_flr e=%0d car=%0d got=%h", e, i, flr_rqst[i]);
                    end
                end
                if (e == 7) begin
                    checks++;
                    if (pend_cnt[i] !== CW'(2)) begin
                        errors++;
                        $display("FAIL all_cars_pend car=%0d got=%0d want 2", i, pend_cnt[i]);
                    end
                end
            end
        end
        floor_sense[0] = NF'(1) << a0;
        door_open[0] = 1'b1;
        floor_sense[1] = NF'(1) << a1;
        door_open[1] = 1'b0;
        @(posedge clk);
        @(negedge clk);
        clear_inputs();
        for (int i = 0; i < NL; i++) begin
            checks++;
            if (flr_rqst[i] !== (i == 0 ? mask[0] & ~(NF'(1) << a0) : mask[i])) begin
                errors++;
                $display("FAIL serve_car0 car=%0d got=%h", i, flr_rqst[i]);
            end
        end
        @(posedge clk);
        @(negedge clk);
        checks++;
        if (pend_cnt[0] !== CW'(1) || pend_cnt[1] !== CW'(2)) begin
            errors++;
            $display("FAIL serve_pend got=%0d,%0d want 1,2", pend_cnt[0], pend_cnt[1]);
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        for (int e = 1; e <= 12; e++) begin
            btn_raw[4][7] = 1'b1;
            reset = (e != 3);
            @(posedge clk);
            @(negedge clk);
            checks++;
            if (flr_rqst[4][7] !== (e >= 9)) begin
                errors++;
                $display("FAIL reset_mid e=%0d got=%b want=%b", e, flr_rqst[4][7], e >= 9);
            end
        end
        clear_inputs();
        door_btn_raw[4] = 1'b1;
        repeat (8) @(negedge clk);
        door_btn_raw[4] = 1'b0;
        repeat (5) @(negedge clk);
        checks++;
        if (force_open[4] !== 1'b1) begin
            errors++;
            $display("FAIL hold_pre got=%b want 1", force_open[4]);
        end
        #2 reset = 1'b0;
        #1;
        checks++;
        if (force_open !== '0 || flr_rqst[4] !== '0) begin
            errors++;
            $display("FAIL hold_async_reset force=%h flr=%h want 0", force_open, flr_rqst[4]);
        end
        @(negedge clk);
        reset = 1'b1;
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            reset = ($urandom_range(0, 249) != 0);
            for (int i = 0; i < NL; i++) begin
                for (int f = 0; f < NF; f++)
                    if ($urandom_range(0, 5) == 0) btn_raw[i][f] = ~btn_raw[i][f];
                if ($urandom_range(0, 5) == 0) door_btn_raw[i] = ~door_btn_raw[i];
                floor_sense[i] = ($urandom_range(0, 3) == 0) ? NF'(0)
                               : NF'(1) << $urandom_range(0, NF - 1);
                door_open[i] = ($urandom_range(0, 5) == 0);
            end
            @(posedge clk);
            @(negedge clk);
            for (int i = 0; i < NL; i++) begin
                checks++;
                if (flr_rqst[i] !== exp_flr[i] || pend_cnt[i] !== CW'(exp_pend[i])) begin
                    errors++;
                    $display("FAIL random c=%0d car=%0d flr=%h/%0d want %h/%0d",
                             c, i, flr_rqst[i], pend_cnt[i], exp_flr[i], exp_pend[i]);
                end
            end
            checks++;
            if (force_open !== exp_force) begin
                errors++;
                $display("FAIL random_force c=%0d got=%h want=%h", c, force_open, exp_force);
            end
        end
        reset = 1'b1;
        clear_inputs();
    endtask

    initial begin
        clear_inputs();
        reset = 1'b1;
        #1 reset = 1'b0;
        @(negedge clk);
        test_reset();
        test_single_press();
        test_short_pulse();
        test_clear_collision();
        test_force_open();
        test_all_cars();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
